ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 16-bit pipeline; sits directly upstream of the EX/MEM register.
//  Computes single-cycle ALU ops in one cycle and unsigned MUL/DIV iteratively (1 bit/cycle).
//  MUL/DIV put their second result (high product / remainder) on R15Result for the R15 writeback.
//  Asserts stall to freeze upstream stages while a multi-cycle op is in flight.
// PARAMETERS
//  DATA_W  16  operand/result width; also the MUL/DIV iteration count
//  REG_W   4   register-specifier width
//  OP_W    4   ALU opcode width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  inValid     in   1       instruction present on the inputs this cycle
//  aluOp       in   OP_W    opcode: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 MUL,10 DIV,11 MOV
//  op1Val      in   DATA_W  operand 1
//  op2Val      in   DATA_W  operand 2
//  regOp1      in   REG_W   operand-1 register specifier, passed through
//  regOp2      in   REG_W   operand-2 register specifier, passed through
//  wb          in   1       writeback enable, passed through
//  mem         in   1       memory-access flag, passed through
//  stall       out  1       upstream must hold its inputs
//  outValid    out  1       result valid; one-cycle pulse per instruction
//  ALUResult   out  DATA_W  primary result
//  R15Result   out  DATA_W  high product / remainder; 0 for single-cycle ops
//  outOp1Val   out  DATA_W  registered op1Val
//  outOp2Val   out  DATA_W  registered op2Val
//  outRegOp1   out  REG_W   registered regOp1
//  outRegOp2   out  REG_W   registered regOp2
//  outWB       out  1       registered wb, gated by outValid
//  outMem      out  1       registered mem, gated by outValid
//  divByZero   out  1       high with outValid for a DIV with op2Val==0
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; any in-flight MUL/DIV is discarded.
//  FSM states: IDLE, BUSY (iteration count DATA_W down to 1).
//  - IDLE with inValid and a single-cycle op: result registered at the next edge; outValid=1 for 1 cycle.
//  - IDLE with inValid and MUL/DIV (accept edge): latch operands, specifiers, wb and mem; go to BUSY.
//  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle.
//    The edge ending the DATA_W-th BUSY cycle writes the outputs, pulses outValid and returns to IDLE.
//  - Latency: 1 cycle for single-cycle ops; DATA_W+1 cycles from the accept edge for MUL/DIV.
//  stall = (state==BUSY) | (state==IDLE & inValid & aluOp in {MUL,DIV}); combinational.
//    Result: high for DATA_W+1 cycles per MUL/DIV.
//  Inputs are ignored while BUSY; upstream holds them because of stall.
//  With no valid result: outValid, outWB, outMem and divByZero are 0; data outputs hold their last values.
//  Arithmetic:
//  - ADD/SUB wrap mod 2^DATA_W, no flags.
//  - Shift amount = op2Val[3:0]; SRA sign-fills.
//  - SLT is a signed compare; result 1 or 0.
//  - MUL is unsigned 32-bit: ALUResult=low half, R15Result=high half.
//  - DIV is unsigned: ALUResult=quotient, R15Result=remainder.
//  - DIV by 0: quotient 0xFFFF, remainder=op1Val, divByZero=1; the full DATA_W+1 latency still applies.
//  - MOV: ALUResult=op2Val. Opcodes 12-15: ALUResult=0, R15Result=0, still valid.
//  Back-to-back: a single-cycle op in the cycle after a MUL/DIV completes is accepted with no bubble.
//  Reset during BUSY: immediate abort; stall drops asynchronously with reset.
// TESTING
//  ADD 0x7FFF+0x0001 -> next cycle ALUResult=0x8000, R15Result=0, outValid 1 cycle, stall=0.
//  MUL 0x1234*0x0100 -> stall high 17 cycles; then ALUResult=0x3400, R15Result=0x0012, outValid 1 cycle.
//  DIV 100/7 -> after 17 cycles: ALUResult=0x000E, R15Result=0x0002, divByZero=0.
//  DIV 0x1234/0 -> ALUResult=0xFFFF, R15Result=0x1234, divByZero=1, same latency.
//  MUL, then rst=0 in BUSY cycle 8 -> outputs all 0, stall=0, no outValid; then ADD 3+4 -> 0x0007 next cycle.
//  SRA 0x8000 by 4 -> 0xF800; SLT 0xFFFF,0x0001 -> 1; wb=1 with inValid=0 -> outWB stays 0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline, feeding the EX/MEM register.
//
// Single-cycle ALU ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, MOV) are
// registered at the edge after they are presented. Unsigned MUL and DIV run
// iteratively at one bit per cycle. Their second result (the high product or
// the remainder) goes out on R15Result for the R15 writeback.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   inValid, aluOp            instruction present / opcode
//   op1Val, op2Val            operands
//   regOp1, regOp2, wb, mem   sideband fields, registered through with the result
//   stall                     combinational; upstream holds its inputs while high
//   outValid                  one-cycle pulse per completed instruction
//   ALUResult, R15Result      primary / secondary results
//   outOp1Val, outOp2Val      registered operands of the completed instruction
//   outRegOp1, outRegOp2      registered register specifiers
//   outWB, outMem             registered wb/mem, gated by outValid
//   divByZero                 pulses with outValid for a DIV whose divisor is 0
//
// FSM states
//   state | meaning
//   IDLE  | accepting instructions; single-cycle ops complete from here
//   BUSY  | MUL/DIV iterating; cnt counts DATA_W down to 1
module ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  input  logic [OP_W-1:0]   aluOp,
  input  logic [DATA_W-1:0] op1Val,
  input  logic [DATA_W-1:0] op2Val,
  input  logic [REG_W-1:0]  regOp1,
  input  logic [REG_W-1:0]  regOp2,
  input  logic              wb,
  input  logic              mem,
  output logic              stall,
  output logic              outValid,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] R15Result,
  output logic [DATA_W-1:0] outOp1Val,
  output logic [DATA_W-1:0] outOp2Val,
  output logic [REG_W-1:0]  outRegOp1,
  output logic [REG_W-1:0]  outRegOp2,
  output logic              outWB,
  output logic              outMem,
  output logic              divByZero
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(9);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(11);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, stateNext;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] aReg, bReg;    // operands as accepted
  logic [DATA_W-1:0] hiReg, loReg;  // MUL: partial product / multiplier; DIV: remainder / quotient
  logic [REG_W-1:0]  rOp1Reg, rOp2Reg;
  logic              wbReg, memReg, isDivReg;

  logic              isMulDiv;
  logic              lastStep;
  logic [DATA_W-1:0] aluRes;
  logic [DATA_W-1:0] hiNext, loNext;
  logic [DATA_W:0]   mulSum;
  logic [DATA_W:0]   divShift, divTrial;
  logic [3:0]        shAmt;

  assign isMulDiv = (aluOp == OP_MUL) || (aluOp == OP_DIV);
  assign lastStep = (cnt == CNT_W'(1));
  assign shAmt    = op2Val[3:0];

  // stall is gated with rst so it drops the moment reset asserts, even with a
  // MUL/DIV still presented on the inputs.
  assign stall = rst & ((state == BUSY) || (state == IDLE && inValid && isMulDiv));

  always_comb begin
    aluRes = '0;
    case (aluOp)
      OP_ADD: aluRes = op1Val + op2Val;
      OP_SUB: aluRes = op1Val - op2Val;
      OP_AND: aluRes = op1Val & op2Val;
      OP_OR:  aluRes = op1Val | op2Val;
      OP_XOR: aluRes = op1Val ^ op2Val;
      OP_SLL: aluRes = op1Val << shAmt;
      OP_SRL: aluRes = op1Val >> shAmt;
      OP_SRA: aluRes = $unsigned($signed(op1Val) >>> shAmt);
      OP_SLT: aluRes = {{(DATA_W-1){1'b0}}, ($signed(op1Val) < $signed(op2Val))};
      OP_MOV: aluRes = op2Val;
      default: aluRes = '0;
    endcase
  end

  // One iteration step. MUL: add the multiplicand when the multiplier LSB is
  // set, then shift {carry, hi, lo} right. DIV (restoring): shift the next
  // dividend bit into the remainder and keep the difference if it did not
  // borrow. A zero divisor never borrows, which naturally gives a quotient of
  // all ones and a remainder equal to the dividend.
  always_comb begin
    mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, bReg} : '0);
    divShift = {hiReg, loReg[DATA_W-1]};
    divTrial = divShift - {1'b0, bReg};
    hiNext   = hiReg;
    loNext   = loReg;
    if (isDivReg) begin
      if (!divTrial[DATA_W]) begin
        hiNext = divTrial[DATA_W-1:0];
        loNext = {loReg[DATA_W-2:0], 1'b1};
      end else begin
        hiNext = divShift[DATA_W-1:0];
        loNext = {loReg[DATA_W-2:0], 1'b0};
      end
    end else begin
      hiNext = mulSum[DATA_W:1];
      loNext = {mulSum[0], loReg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (inValid && isMulDiv) stateNext = BUSY;
      BUSY:    if (lastStep) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      aReg      <= '0;
      bReg      <= '0;
      hiReg     <= '0;
      loReg     <= '0;
      rOp1Reg   <= '0;
      rOp2Reg   <= '0;
      wbReg     <= 1'b0;
      memReg    <= 1'b0;
      isDivReg  <= 1'b0;
      outValid  <= 1'b0;
      ALUResult <= '0;
      R15Result <= '0;
      outOp1Val <= '0;
      outOp2Val <= '0;
      outRegOp1 <= '0;
      outRegOp2 <= '0;
      outWB     <= 1'b0;
      outMem    <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      outValid  <= 1'b0;
      outWB     <= 1'b0;
      outMem    <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            if (isMulDiv) begin
              cnt      <= CNT_W'(DATA_W);
              aReg     <= op1Val;
              bReg     <= op2Val;
              hiReg    <= '0;
              loReg    <= op1Val;
              rOp1Reg  <= regOp1;
              rOp2Reg  <= regOp2;
              wbReg    <= wb;
              memReg   <= mem;
              isDivReg <= (aluOp == OP_DIV);
            end else begin
              outValid  <= 1'b1;
              ALUResult <= aluRes;
              R15Result <= '0;
              outOp1Val <= op1Val;
              outOp2Val <= op2Val;
              outRegOp1 <= regOp1;
              outRegOp2 <= regOp2;
              outWB     <= wb;
              outMem    <= mem;
            end
          end
        end
        BUSY: begin
          hiReg <= hiNext;
          loReg <= loNext;
          cnt   <= cnt - CNT_W'(1);
          if (lastStep) begin
            outValid  <= 1'b1;
            ALUResult <= loNext;
            R15Result <= hiNext;
            outOp1Val <= aReg;
            outOp2Val <= bReg;
            outRegOp1 <= rOp1Reg;
            outRegOp2 <= rOp2Reg;
            outWB     <= wbReg;
            outMem    <= memReg;
            divByZero <= isDivReg && (bReg == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [3:0]  aluOp;
  logic [15:0] op1Val, op2Val;
  logic [3:0]  regOp1, regOp2;
  logic        wb, mem;
  logic        stall, outValid;
  logic [15:0] ALUResult, R15Result, outOp1Val, outOp2Val;
  logic [3:0]  outRegOp1, outRegOp2;
  logic        outWB, outMem, divByZero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .inValid(inValid), .aluOp(aluOp),
    .op1Val(op1Val), .op2Val(op2Val), .regOp1(regOp1), .regOp2(regOp2),
    .wb(wb), .mem(mem), .stall(stall), .outValid(outValid),
    .ALUResult(ALUResult), .R15Result(R15Result),
    .outOp1Val(outOp1Val), .outOp2Val(outOp2Val),
    .outRegOp1(outRegOp1), .outRegOp2(outRegOp2),
    .outWB(outWB), .outMem(outMem), .divByZero(divByZero)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        wb;
    logic        mem;
    logic [15:0] expRes;
    logic [15:0] expR15;
    logic        expDbz;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    inValid = 1'b0; aluOp = 4'd0; op1Val = 16'h0; op2Val = 16'h0;
    regOp1 = 4'd0; regOp2 = 4'd0; wb = 1'b0; mem = 1'b0;
  endtask

  // Present one instruction, count stall cycles and edges until outValid,
  // then check all outputs and that the valid pulse lasts one cycle.
  task automatic runVec(input string tag, input vec_t v);
    int  edges, stallCnt, expLat;
    bit  got;
    expLat = (v.op == 4'd9 || v.op == 4'd10) ? 17 : 1;
    @(negedge clk);
    inValid = 1'b1; aluOp = v.op; op1Val = v.a; op2Val = v.b;
    regOp1 = v.r1; regOp2 = v.r2; wb = v.wb; mem = v.mem;
    edges = 0; stallCnt = 0; got = 0;
    while (!got && edges < 40) begin
      #1;
      if (stall) stallCnt++;
      @(posedge clk); #1;
      edges++;
      if (outValid) got = 1;
      else begin
        @(negedge clk);
        // inputs must be ignored while busy
        inValid = 1'b0; aluOp = 4'd0; op1Val = 16'hDEAD; op2Val = 16'hBEEF;
        regOp1 = ~v.r1; regOp2 = ~v.r2; wb = ~v.wb; mem = ~v.mem;
      end
    end
    chk({tag, " completed"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(edges), 32'(expLat));
    chk({tag, " stall cycles"}, 32'(stallCnt), 32'(expLat == 1 ? 0 : 17));
    chk({tag, " ALUResult"}, 32'(ALUResult), 32'(v.expRes));
    chk({tag, " R15Result"}, 32'(R15Result), 32'(v.expR15));
    chk({tag, " divByZero"}, 32'(divByZero), 32'(v.expDbz));
    chk({tag, " side"}, {outOp1Val, outOp2Val}, {v.a, v.b});
    chk({tag, " regs/wb/mem"}, {22'd0, outRegOp1, outRegOp2, outWB, outMem},
        {22'd0, v.r1, v.r2, v.wb, v.mem});
    @(negedge clk);
    idleInputs();
    @(posedge clk); #1;
    chk({tag, " pulse end"}, {29'd0, outValid, outWB, outMem}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int pulses;
    //            op     a         b         r1    r2    wb    mem   res       r15       dbz
    vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 4'd1, 4'd2, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0};
    vecs[1]  = '{4'd1,  16'h0000, 16'h0001, 4'd3, 4'd4, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
    vecs[2]  = '{4'd2,  16'hF0F0, 16'h3C3C, 4'd5, 4'd6, 1'b1, 1'b1, 16'h3030, 16'h0000, 1'b0};
    vecs[3]  = '{4'd3,  16'hF0F0, 16'h0F01, 4'd7, 4'd8, 1'b1, 1'b0, 16'hFFF1, 16'h0000, 1'b0};
    vecs[4]  = '{4'd4,  16'hAAAA, 16'hFFFF, 4'd9, 4'd1, 1'b1, 1'b0, 16'h5555, 16'h0000, 1'b0};
    vecs[5]  = '{4'd5,  16'h0001, 16'h0013, 4'd2, 4'd3, 1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0};
    vecs[6]  = '{4'd6,  16'h8000, 16'h0004, 4'd4, 4'd5, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0};
    vecs[7]  = '{4'd7,  16'h8000, 16'h0004, 4'd6, 4'd7, 1'b1, 1'b0, 16'hF800, 16'h0000, 1'b0};
    vecs[8]  = '{4'd8,  16'hFFFF, 16'h0001, 4'd8, 4'd9, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0};
    vecs[9]  = '{4'd8,  16'h0001, 16'hFFFF, 4'd1, 4'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{4'd11, 16'h5555, 16'h1234, 4'd2, 4'd2, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0};
    vecs[11] = '{4'd12, 16'h5555, 16'h1234, 4'd3, 4'd3, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{4'd9,  16'h1234, 16'h0100, 4'd4, 4'd5, 1'b1, 1'b0, 16'h3400, 16'h0012, 1'b0};
    vecs[13] = '{4'd9,  16'hFFFF, 16'hFFFF, 4'd6, 4'd7, 1'b0, 1'b1, 16'h0001, 16'hFFFE, 1'b0};
    vecs[14] = '{4'd10, 16'd100,  16'd7,    4'd8, 4'd9, 1'b1, 1'b0, 16'h000E, 16'h0002, 1'b0};
    vecs[15] = '{4'd10, 16'h1234, 16'h0000, 4'd1, 4'd3, 1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b1};
    vecs[16] = '{4'd10, 16'h0005, 16'h0009, 4'd2, 4'd4, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0};
    vecs[17] = '{4'd15, 16'hFFFF, 16'hFFFF, 4'd5, 4'd6, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};

    idleInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {ALUResult, R15Result}, 32'd0);
    chk("reset flags", {27'd0, stall, outValid, outWB, outMem, divByZero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      runVec($sformatf("vec%0d", i), vecs[i]);

    // wb asserted without inValid must not reach outWB
    @(negedge clk);
    wb = 1'b1; mem = 1'b1; aluOp = 4'd0;
    @(posedge clk); #1;
    chk("wb without inValid", {29'd0, outValid, outWB, outMem}, 32'd0);
    @(negedge clk);
    idleInputs();

    // back-to-back: ADD in the cycle right after a MUL completes
    @(negedge clk);
    inValid = 1'b1; aluOp = 4'd9; op1Val = 16'hFFFF; op2Val = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    repeat (16) @(posedge clk);
    #1;
    chk("b2b mul valid", 32'(outValid), 32'd1);
    chk("b2b mul result", {R15Result, ALUResult}, 32'h0001FFFE);
    @(negedge clk);
    inValid = 1'b1; aluOp = 4'd0; op1Val = 16'h0001; op2Val = 16'h0001;
    #1;
    chk("b2b add stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("b2b add valid", 32'(outValid), 32'd1);
    chk("b2b add result", {R15Result, ALUResult}, 32'h00000002);
    @(negedge clk);
    idleInputs();

    // reset in BUSY cycle 8 aborts the MUL
    @(negedge clk);
    inValid = 1'b1; aluOp = 4'd9; op1Val = 16'h1234; op2Val = 16'h0100; wb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    chk("busy before reset stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort stall", 32'(stall), 32'd0);
    chk("abort outputs", {ALUResult, R15Result}, 32'd0);
    chk("abort flags", {28'd0, outValid, outWB, outMem, divByZero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (outValid || stall) pulses++;
    end
    chk("no result after abort", 32'(pulses), 32'd0);
    v = '{4'd0, 16'd3, 16'd4, 4'd1, 4'd2, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0};
    runVec("add after abort", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
